// File: rtl/fifo_pkt.sv
// fifo_pkt: packet FIFO with speculative writes; pushed entries stay hidden until
// committed, and can be dropped as a group by discard.
`default_nettype none

module fifo_pkt #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cg,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_commit,
  input  logic             i_discard,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_pushed,
  output logic             o_popped,
  input  logic [CNT_W-1:0] i_afThresh,
  input  logic [CNT_W-1:0] i_aeThresh,
  output logic             o_almostFull,
  output logic             o_almostEmpty,
  output logic [CNT_W-1:0] o_nCommitted,
  output logic [CNT_W-1:0] o_nSpec
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0] wr_spec_q, wr_spec_d;
  logic [CNT_W-1:0] n_committed_q, n_committed_d;
  logic [CNT_W-1:0] n_spec_q, n_spec_d;

  logic             push, pop, commit, discard, flush;
  logic [PTR_W-1:0] wr_spec_inc;
  logic [CNT_W:0]   total;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign total   = {1'b0, n_committed_q} + {1'b0, n_spec_q};
  assign o_ready = (total != (CNT_W + 1)'(DEPTH));
  assign o_valid = (n_committed_q != '0);

  // Strobes are masked by reset so nothing reads as accepted while held in reset.
  assign flush   = i_cg & i_flush;
  assign push    = i_rst_n & i_cg & i_valid & o_ready & ~i_flush;
  assign pop     = i_rst_n & i_cg & i_ready & o_valid & ~i_flush;
  assign discard = i_cg & i_discard & ~i_flush;
  assign commit  = i_cg & i_commit & ~i_discard & ~i_flush;

  assign wr_spec_inc = push ? ptr_inc(wr_spec_q) : wr_spec_q;

  always_comb begin
    rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_commit_d   = wr_commit_q;
    wr_spec_d     = wr_spec_inc;
    n_spec_d      = n_spec_q + CNT_W'(push);
    n_committed_d = n_committed_q - CNT_W'(pop);
    if (flush) begin
      rd_ptr_d      = '0;
      wr_commit_d   = '0;
      wr_spec_d     = '0;
      n_spec_d      = '0;
      n_committed_d = '0;
    end else if (discard) begin
      wr_spec_d = wr_commit_q;
      n_spec_d  = '0;
    end else if (commit) begin
      // The same-cycle push is folded into the committed region.
      wr_commit_d   = wr_spec_inc;
      n_spec_d      = '0;
      n_committed_d = n_committed_q + n_spec_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q      <= '0;
      wr_commit_q   <= '0;
      wr_spec_q     <= '0;
      n_committed_q <= '0;
      n_spec_q      <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_commit_q   <= wr_commit_d;
      wr_spec_q     <= wr_spec_d;
      n_committed_q <= n_committed_d;
      n_spec_q      <= n_spec_d;
    end
  end

  generate
    if (FLOPS_NOT_MEM != 0) begin : g_flops
      logic [DEPTH-1:0][WIDTH-1:0] store_q;
      always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (push && wr_spec_q == PTR_W'(i)) store_q[i] <= i_data;
        end
      end
      assign o_data = store_q[rd_ptr_q];
    end else begin : g_mem
      logic [WIDTH-1:0] mem_q [DEPTH];
      always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_spec_q] <= i_data;
      end
      assign o_data = mem_q[rd_ptr_q];
    end
  endgenerate

  assign o_pushed      = push;
  assign o_popped      = pop;
  assign o_almostFull  = (total >= {1'b0, i_afThresh});
  assign o_almostEmpty = (n_committed_q <= i_aeThresh);
  assign o_nCommitted  = n_committed_q;
  assign o_nSpec       = n_spec_q;

endmodule

`default_nettype wire
